ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Upstream driver for the configuration chain that runs through the IO tiles and their DFFRQ config memories.
- Accepts configuration bytes over a valid/ready stream and serializes them LSB-first onto ccff_head, with a per-bit shift enable.
- Captures the bits falling out of ccff_tail into readback bytes, so the previous chain contents can be read out.
- Holds the IO isolation signal asserted while the fabric is unconfigured or being reconfigured.

Parameters:
- CHAIN_LEN, 64, total chain length in bits; must be 1 or more.
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  the only clock; all state updates on its rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a full chain load; ignored unless in IDLE.
- cfg_data  input  8  next configuration byte; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  chain shifts on this edge; ccff_head is meaningful only while high.
- ccff_tail  input  1  serial bit out of the chain end.
- rb_data  output  8  readback byte; first tail bit is in bit 0.
- rb_valid  output  1  rb_data is valid; held until accepted.
- rb_ready  input  1  consumer accepts rb_data.
- isol_n  output  1  IO isolation; low = isolated.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values: cfg_ready=0, ccff_head=0, ccff_shift_en=0, rb_data=0, rb_valid=0, isol_n=0, busy=0, done=0; bit counter=0; state=IDLE. Reset mid-load aborts the load immediately with the same values.
- States:
  - IDLE: wait for start. start=1 -> FETCH; isol_n goes 0 in that same transition.
  - FETCH: cfg_ready=1. On cfg_valid&&cfg_ready, latch the byte into the shift register, set the in-byte index to 0, go to SHIFT. Data accepted in the cycle after start is legal.
  - SHIFT: each cycle not stalled:
    - ccff_shift_en=1 and ccff_head = shift-register bit 0.
    - ccff_tail is sampled on that same edge into the readback register at the current index (this is the old value leaving the chain).
    - The shift register moves right, the in-byte index and the bit counter each increment.
  - Stall: ccff_shift_en=0 while rb_valid=1 and rb_ready=0 and the readback register is full. The chain never advances while a readback byte would be lost.
  - Readback byte complete: after 8 captured bits, or on the final bit, rb_data is loaded and rb_valid=1. rb_valid clears on the rb_valid&&rb_ready cycle.
  - Final byte: unused rb_data bits are 0. Excess cfg_data bits are discarded, not shifted.
  - After 8 bits with bit counter < CHAIN_LEN -> FETCH.
  - When bit counter = CHAIN_LEN -> DRAIN.
  - DRAIN: wait until rb_valid=0 -> DONE.
  - DONE: done=1 and isol_n=1 for one cycle, then IDLE. isol_n stays 1 until the next start or pReset.
- Latency:
  - Start to first shift: 2 cycles if cfg_valid is already high.
  - Unstalled load: ceil(CHAIN_LEN/8) FETCH cycles plus CHAIN_LEN shift cycles.
- cfg_ready is never high outside FETCH.
- ccff_shift_en is never high outside SHIFT.
- The bit counter saturates at CHAIN_LEN; it is never exceeded.
- start while busy is ignored; it is neither queued nor a restart.
- cfg_valid dropping in FETCH simply waits; the chain holds with ccff_shift_en=0.
- Simultaneous rb_ready and new-byte completion in the same cycle: the old byte is accepted and the new byte is loaded; there is no stall.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, DRAIN, DONE);
  - CFG_BYTE_W=8;
  - a function computing ceil(CHAIN_LEN/8).
- One sub-module, ccff_rb_packer: the tail-capture register, the index, and the rb_valid/rb_ready holding register, with a stall output to the FSM.

Test Plan:
- Basic load: CHAIN_LEN=16, start, bytes 0xA5 then 0x3C with rb_ready=1 -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Exactly 16 ccff_shift_en cycles, done pulses once, isol_n 0 during the load and 1 afterwards.
- Readback: model chain preloaded with 0x1234, i.e. tail bits LSB of 0x34 first -> rb_data 0x34 then 0x12. A second load returns the bytes written by the first.
- Backpressure: hold rb_ready=0 after the first readback byte -> ccff_shift_en stays 0 once 8 more bits are captured. Release -> shifting resumes with no bit lost or duplicated.
- Partial byte: CHAIN_LEN=12, bytes 0xFF and 0x0F -> 12 shifts. The second rb_data has bits [7:4]=0. The upper cfg bits are never driven.
- cfg_valid gaps and a start pulse while busy -> no extra loads and no shifts during gaps; the total shift count equals CHAIN_LEN.
- pReset asserted mid-SHIFT -> next cycle all outputs at reset values, isol_n=0, and a fresh start performs a full CHAIN_LEN load.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the loader FSM states, the config byte width and a byte-count helper.
package ccff_pkg;

    localparam int CFG_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    // Number of config bytes needed to cover a chain of len bits.
    function automatic int n_bytes(input int len);
        return (len + CFG_BYTE_W - 1) / CFG_BYTE_W;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Packs bits leaving the chain tail into readback bytes (first bit in bit 0).
// Ports: prog_clk/pReset; i_clr resets the in-byte index, i_shift captures
// i_tail, i_last marks the final chain bit; o_rb_data/o_rb_valid with
// i_rb_ready handshake; o_byte_end flags index 7; o_stall holds the chain.
module ccff_rb_packer
    import ccff_pkg::*;
(
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  i_clr,
    input  logic                  i_shift,
    input  logic                  i_last,
    input  logic                  i_tail,
    input  logic                  i_rb_ready,
    output logic [CFG_BYTE_W-1:0] o_rb_data,
    output logic                  o_rb_valid,
    output logic                  o_byte_end,
    output logic                  o_stall
);

    logic [CFG_BYTE_W-1:0] r_cap;
    logic [CFG_BYTE_W-1:0] r_data;
    logic [2:0]            r_idx;
    logic                  r_full;
    logic                  r_valid;

    logic [CFG_BYTE_W-1:0] w_cap_next;
    logic                  w_complete;
    logic                  w_slot_free;

    assign o_rb_data   = r_data;
    assign o_rb_valid  = r_valid;
    assign o_byte_end  = (r_idx == 3'd7);
    // A finished byte is parked in r_cap; the chain may not move again
    // until the output slot takes it.
    assign o_stall     = r_full && !i_rb_ready;
    assign w_complete  = i_shift && (o_byte_end || i_last);
    assign w_slot_free = !r_valid || i_rb_ready;

    // Starting a new byte clears stale bits so a short final byte reads 0 above.
    always_comb begin
        w_cap_next        = (r_idx == 3'd0) ? '0 : r_cap;
        w_cap_next[r_idx] = i_tail;
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_cap   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (i_clr) begin
                r_idx <= '0;
            end else if (i_shift) begin
                r_idx <= r_idx + 3'd1;
            end
            if (i_shift) begin
                r_cap <= w_cap_next;
            end
            if (r_full) begin
                if (i_rb_ready) begin
                    r_data <= r_cap;
                    r_full <= w_complete;
                end
            end else if (w_complete) begin
                if (w_slot_free) begin
                    r_data  <= w_cap_next;
                    r_valid <= 1'b1;
                end else begin
                    r_full <= 1'b1;
                end
            end else if (r_valid && i_rb_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the IO-tile configuration chain from a byte stream, LSB first, and
// returns the displaced chain contents as readback bytes.
// Ports: start, cfg_data/valid/ready in; ccff_head/shift_en/tail chain side;
// rb_data/valid/ready readback; isol_n (low = isolated), busy, done status.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic [CFG_BYTE_W-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  ccff_shift_en,
    input  logic                  ccff_tail,
    output logic [CFG_BYTE_W-1:0] rb_data,
    output logic                  rb_valid,
    input  logic                  rb_ready,
    output logic                  isol_n,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t                r_state;
    logic [CFG_BYTE_W-1:0] r_sr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_isol_n;
    logic                  r_done;

    logic w_stall;
    logic w_shift;
    logic w_last;
    logic w_byte_end;
    logic w_accept;

    assign cfg_ready     = (r_state == FETCH);
    assign w_accept      = cfg_ready && cfg_valid;
    assign w_shift       = (r_state == SHIFT) && !w_stall;
    assign w_last        = (r_cnt == LAST_BIT);
    assign ccff_shift_en = w_shift;
    assign ccff_head     = w_shift && r_sr[0];
    assign busy          = (r_state != IDLE);
    assign isol_n        = r_isol_n;
    assign done          = r_done;

    ccff_rb_packer u_packer (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .i_clr      (w_accept),
        .i_shift    (w_shift),
        .i_last     (w_last),
        .i_tail     (ccff_tail),
        .i_rb_ready (rb_ready),
        .o_rb_data  (rb_data),
        .o_rb_valid (rb_valid),
        .o_byte_end (w_byte_end),
        .o_stall    (w_stall)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_isol_n <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_isol_n <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        r_sr    <= cfg_data;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_shift) begin
                        r_sr  <= r_sr >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Final bit wins over byte end: leftover cfg bits drop.
                        if (w_last) begin
                            r_state <= DRAIN;
                        end else if (w_byte_end) begin
                            r_state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (!rb_valid) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_isol_n <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader with a bit-level chain model.
// Three instances (16, 12 and 40 bit chains) share one clock and reset.
module tb_ccff_chain_loader;
    import ccff_pkg::*;

    localparam int ND = 3;

    function automatic int len_of(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 12 : 40);
    endfunction

    logic       clk = 1'b0;
    logic       pReset = 1'b1;
    logic       start_s    [ND];
    logic [7:0] cfg_data_s [ND];
    logic       cfg_valid_s[ND];
    logic       rb_ready_s [ND];
    logic       tail_s     [ND];
    logic       cfg_ready_o[ND];
    logic       head_o     [ND];
    logic       shen_o     [ND];
    logic [7:0] rb_data_o  [ND];
    logic       rb_valid_o [ND];
    logic       isol_n_o   [ND];
    logic       busy_o     [ND];
    logic       done_o     [ND];

    logic [63:0] chain_m[ND];
    byte         tx_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign tail_s[g] = chain_m[g][0];
        ccff_chain_loader #(
            .CHAIN_LEN (len_of(g)),
            .CNT_W     (16)
        ) u_dut (
            .prog_clk      (clk),
            .pReset        (pReset),
            .start         (start_s[g]),
            .cfg_data      (cfg_data_s[g]),
            .cfg_valid     (cfg_valid_s[g]),
            .cfg_ready     (cfg_ready_o[g]),
            .ccff_head     (head_o[g]),
            .ccff_shift_en (shen_o[g]),
            .ccff_tail     (tail_s[g]),
            .rb_data       (rb_data_o[g]),
            .rb_valid      (rb_valid_o[g]),
            .rb_ready      (rb_ready_s[g]),
            .isol_n        (isol_n_o[g]),
            .busy          (busy_o[g]),
            .done          (done_o[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return {50'd0, cfg_ready_o[d], head_o[d], shen_o[d], rb_data_o[d],
                rb_valid_o[d], isol_n_o[d], busy_o[d], done_o[d]};
    endfunction

    task automatic fill_rand(input int d);
        tx_q.delete();
        for (int k = 0; k < (len_of(d) + 7) / 8; k++) begin
            tx_q.push_back(byte'($urandom));
        end
    endtask

    // pv/pr: percent of cycles cfg_valid/rb_ready are high; hold: cycles
    // rb_ready is forced low; abort_at: shift count at which pReset fires.
    task automatic run_load(input int d, input int pv, input int pr,
                            input int hold, input bit spam,
                            input int abort_at);
        int          len;
        int          nb;
        int          nsh;
        int          ndone;
        int          nrdy;
        int          nbad;
        int          niso;
        int          first_sh;
        int          feed;
        int          nidle;
        bit          fin;
        bit          aborted;
        bit          sh_now;
        logic        sh_bit;
        logic [63:0] mask;
        logic [63:0] old_m;
        logic [63:0] exp_new;
        logic [63:0] got_head;
        logic [7:0]  rb_got[$];

        len      = len_of(d);
        nb       = (len + 7) / 8;
        mask     = (64'd1 << len) - 64'd1;
        old_m    = chain_m[d] & mask;
        exp_new  = '0;
        for (int k = 0; k < nb; k++) begin
            exp_new[8*k +: 8] = tx_q[k];
        end
        exp_new  = exp_new & mask;
        got_head = '0;
        nsh = 0; ndone = 0; nrdy = 0; nbad = 0; niso = 0;
        first_sh = -1; feed = 0; fin = 0; aborted = 0;

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            start_s[d] = (cyc == 0) ||
                (spam && busy_o[d] && !done_o[d] &&
                 $urandom_range(0, 3) == 0);
            cfg_valid_s[d] = (feed < nb) && ($urandom_range(1, 100) <= pv);
            cfg_data_s[d]  = (feed < nb) ? tx_q[feed] : 8'($urandom);
            rb_ready_s[d]  = (cyc < hold) ? 1'b0 :
                             ($urandom_range(1, 100) <= pr);
            #1;
            if (hold > 0 && cyc == hold - 1) begin
                check("hold_shift_count", nsh, 2 * 8);
                check("hold_shift_en", shen_o[d], 0);
            end
            sh_now = shen_o[d];
            sh_bit = head_o[d];
            if (sh_now) begin
                if (nsh < 64) got_head[nsh] = sh_bit;
                if (first_sh < 0) first_sh = cyc;
                nsh++;
            end
            if (cfg_ready_o[d]) nrdy++;
            if (cfg_ready_o[d] && cfg_valid_s[d]) feed++;
            if (rb_valid_o[d] && rb_ready_s[d]) rb_got.push_back(rb_data_o[d]);
            if (cfg_ready_o[d] && sh_now) nbad++;
            if (busy_o[d] && !done_o[d] && isol_n_o[d]) niso++;
            if (done_o[d]) begin
                ndone++;
                fin = 1;
            end
            if (abort_at >= 0 && sh_now && nsh == abort_at) begin
                pReset  = 1'b1;
                aborted = 1;
                fin     = 1;
            end
            @(posedge clk);
            #1;
            if (sh_now) begin
                chain_m[d] = chain_m[d] >> 1;
                chain_m[d][len-1] = sh_bit;
            end
        end
        start_s[d]     = 1'b0;
        cfg_valid_s[d] = 1'b0;

        if (aborted) begin
            check("abort_outputs", outs(d), 64'd0);
            check("abort_isol_n", isol_n_o[d], 0);
            @(negedge clk);
            pReset = 1'b0;
        end else if (!fin) begin
            check("load_timeout", 0, 1);
        end else begin
            check("shift_count", nsh, len);
            check("head_bits", got_head & mask, exp_new);
            check("rb_count", rb_got.size(), nb);
            for (int k = 0; k < nb && k < rb_got.size(); k++) begin
                check("rb_byte", rb_got[k], old_m[8*k +: 8]);
            end
            check("done_pulses", ndone, 1);
            check("isol_during_load", niso, 0);
            check("ready_with_shift", nbad, 0);
            if (pv == 100) begin
                check("fetch_cycles", nrdy, nb);
                check("first_shift_lat", first_sh, 2);
            end
            nidle = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                #1;
                if (busy_o[d] || shen_o[d] || done_o[d] || !isol_n_o[d]) begin
                    nidle++;
                end
            end
            check("idle_after_done", nidle, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            start_s[d]     = 1'b0;
            cfg_data_s[d]  = 8'h00;
            cfg_valid_s[d] = 1'b0;
            rb_ready_s[d]  = 1'b0;
        end
        chain_m[0] = 64'h1234;
        chain_m[1] = 64'hFFF;
        chain_m[2] = {$urandom, $urandom} & ((64'd1 << 40) - 64'd1);

        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check("reset_outputs", outs(d), 64'd0);
        end
        @(negedge clk);
        pReset = 1'b0;

        tx_q = '{8'hA5, 8'h3C};
        run_load(0, 100, 100, 0, 0, -1);
        check("basic_chain", chain_m[0] & 64'hFFFF, 64'h3CA5);

        fill_rand(0);
        run_load(0, 70, 70, 0, 0, -1);

        tx_q = '{8'hFF, 8'h0F};
        run_load(1, 100, 100, 0, 0, -1);
        check("partial_chain", chain_m[1] & 64'hFFF, 64'hFFF);

        fill_rand(2);
        run_load(2, 100, 100, 40, 0, -1);

        for (int r = 0; r < 6; r++) begin
            int d;
            d = $urandom_range(0, ND - 1);
            fill_rand(d);
            run_load(d, $urandom_range(40, 100), $urandom_range(30, 100),
                     0, 1'($urandom_range(0, 1)), -1);
        end

        fill_rand(2);
        run_load(2, 100, 100, 0, 0, $urandom_range(3, 30));
        fill_rand(2);
        run_load(2, 100, 100, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
